// File: rtl/spawn_pkg.sv
// spawn_pkg: shared slot state encoding and off-screen defaults for the spawner pool
package spawn_pkg;
  typedef enum logic {IDLE, MOVE} slot_state_e;
  localparam int HOFF_DEF = 1000;
  localparam int VOFF_DEF = 1000;
endpackage

// File: rtl/spawn_slot.sv
// spawn_slot: single object FSM with exact linear interpolation from src to dst
module spawn_slot import spawn_pkg::*; #(
  parameter int HWIDTH    = 11,
  parameter int VWIDTH    = 11,
  parameter int STEP_LOG2 = 5,
  parameter int HOFF      = HOFF_DEF,
  parameter int VOFF      = VOFF_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic                     load,
  input  logic                     kill,
  input  logic signed [HWIDTH-1:0] hsrc,
  input  logic signed [VWIDTH-1:0] vsrc,
  input  logic signed [HWIDTH-1:0] hdst,
  input  logic signed [VWIDTH-1:0] vdst,
  output logic signed [HWIDTH-1:0] hoffset,
  output logic signed [VWIDTH-1:0] voffset,
  output logic                     active,
  output logic                     done
);
  localparam int HPW = HWIDTH + STEP_LOG2 + 2;
  localparam int VPW = VWIDTH + STEP_LOG2 + 2;
  localparam logic [STEP_LOG2:0] KLAST = {1'b1, {STEP_LOG2{1'b0}}};
  slot_state_e state_q;
  logic signed [HWIDTH-1:0] hsrc_q, hoff_q, hnext;
  logic signed [VWIDTH-1:0] vsrc_q, voff_q, vnext;
  logic signed [HWIDTH:0] hdelta_q;
  logic signed [VWIDTH:0] vdelta_q;
  logic [STEP_LOG2:0] k_q, kp1;
  logic done_q;
  logic signed [HPW-1:0] hprod, hsh;
  logic signed [VPW-1:0] vprod, vsh;
  assign kp1 = k_q + (STEP_LOG2+1)'(1);
  assign hprod = {{(STEP_LOG2+1){hdelta_q[HWIDTH]}}, hdelta_q} * {{(HWIDTH+1){1'b0}}, kp1};
  assign vprod = {{(STEP_LOG2+1){vdelta_q[VWIDTH]}}, vdelta_q} * {{(VWIDTH+1){1'b0}}, kp1};
  assign hsh = hprod >>> STEP_LOG2;
  assign vsh = vprod >>> STEP_LOG2;
  assign hnext = hsrc_q + hsh[HWIDTH-1:0];
  assign vnext = vsrc_q + vsh[VWIDTH-1:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hsrc_q   <= '0;
      vsrc_q   <= '0;
      hdelta_q <= '0;
      vdelta_q <= '0;
      k_q      <= '0;
      hoff_q   <= HWIDTH'(HOFF);
      voff_q   <= VWIDTH'(VOFF);
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        state_q  <= MOVE;
        hsrc_q   <= hsrc;
        vsrc_q   <= vsrc;
        hdelta_q <= {hdst[HWIDTH-1], hdst} - {hsrc[HWIDTH-1], hsrc};
        vdelta_q <= {vdst[VWIDTH-1], vdst} - {vsrc[VWIDTH-1], vsrc};
        k_q      <= '0;
        hoff_q   <= hsrc;
        voff_q   <= vsrc;
      end else if (state_q == MOVE && (kill || (tick && k_q == KLAST))) begin
        state_q <= IDLE;
        hoff_q  <= HWIDTH'(HOFF);
        voff_q  <= VWIDTH'(VOFF);
        done_q  <= ~kill;
      end else if (state_q == MOVE && tick) begin
        k_q    <= kp1;
        hoff_q <= hnext;
        voff_q <= vnext;
      end
    end
  end
  assign hoffset = hoff_q;
  assign voffset = voff_q;
  assign active  = state_q == MOVE;
  assign done    = done_q;
endmodule

// File: rtl/spawn_pool.sv
// spawn_pool: NSLOT concurrent spawners with lowest-free slot allocation
module spawn_pool import spawn_pkg::*; #(
  parameter int HWIDTH    = 11,
  parameter int VWIDTH    = 11,
  parameter int NSLOT     = 4,
  parameter int STEP_LOG2 = 5,
  parameter int HOFF      = HOFF_DEF,
  parameter int VOFF      = VOFF_DEF,
  localparam int SW       = NSLOT > 1 ? $clog2(NSLOT) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic                     req,
  input  logic [HWIDTH-1:0]        req_hsrc,
  input  logic [VWIDTH-1:0]        req_vsrc,
  input  logic [HWIDTH-1:0]        req_hdst,
  input  logic [VWIDTH-1:0]        req_vdst,
  output logic                     req_ready,
  output logic [SW-1:0]            req_slot,
  input  logic [NSLOT-1:0]         kill,
  output logic [NSLOT*HWIDTH-1:0]  hoffset,
  output logic [NSLOT*VWIDTH-1:0]  voffset,
  output logic [NSLOT-1:0]         active,
  output logic [NSLOT-1:0]         done
);
  logic [SW-1:0] free_idx;
  logic accept;
  always_comb begin
    free_idx = '0;
    for (int i = NSLOT-1; i >= 0; i--) if (!active[i]) free_idx = SW'(i);
  end
  assign req_ready = ~&active;
  assign req_slot  = free_idx;
  assign accept    = req && req_ready;
  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    spawn_slot #(
      .HWIDTH(HWIDTH), .VWIDTH(VWIDTH), .STEP_LOG2(STEP_LOG2), .HOFF(HOFF), .VOFF(VOFF)
    ) u_slot (
      .clk(clk),
      .rst(rst),
      .tick(tick),
      .load(accept && free_idx == SW'(g)),
      .kill(kill[g]),
      .hsrc(req_hsrc),
      .vsrc(req_vsrc),
      .hdst(req_hdst),
      .vdst(req_vdst),
      .hoffset(hoffset[g*HWIDTH +: HWIDTH]),
      .voffset(voffset[g*VWIDTH +: VWIDTH]),
      .active(active[g]),
      .done(done[g])
    );
  end
endmodule

// File: tb/tb_spawn_pool.sv
// tb_spawn_pool: randomized and directed checks of spawn_pool against a flight-level model
module tb_spawn_pool;
  localparam int HW = 11, VW = 11, NS = 4, SL = 2, SW = 2;
  localparam int NT = 1 << SL;
  logic clk = 1'b0;
  logic rst, tick, req, req_ready;
  logic [HW-1:0] req_hsrc, req_hdst;
  logic [VW-1:0] req_vsrc, req_vdst;
  logic [SW-1:0] req_slot;
  logic [NS-1:0] kill, active, done;
  logic [NS*HW-1:0] hoffset;
  logic [NS*VW-1:0] voffset;
  int total = 0, bad = 0;
  bit m_act[NS], m_done[NS];
  int m_hs[NS], m_vs[NS], m_hd[NS], m_vd[NS], m_n[NS];

  spawn_pool #(.HWIDTH(HW), .VWIDTH(VW), .NSLOT(NS), .STEP_LOG2(SL), .HOFF(1000), .VOFF(1000)) dut (
    .clk(clk), .rst(rst), .tick(tick), .req(req),
    .req_hsrc(req_hsrc), .req_vsrc(req_vsrc), .req_hdst(req_hdst), .req_vdst(req_vdst),
    .req_ready(req_ready), .req_slot(req_slot), .kill(kill),
    .hoffset(hoffset), .voffset(voffset), .active(active), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int hoff(int i);
    logic signed [HW-1:0] t;
    t = hoffset[i*HW +: HW];
    return int'(t);
  endfunction

  function automatic int voff(int i);
    logic signed [VW-1:0] t;
    t = voffset[i*VW +: VW];
    return int'(t);
  endfunction

  // position after n of NT ticks along the straight line, floor-rounded
  function automatic int exp_h(int i);
    return m_act[i] ? m_hs[i] + (((m_hd[i] - m_hs[i]) * m_n[i]) >>> SL) : 1000;
  endfunction

  function automatic int exp_v(int i);
    return m_act[i] ? m_vs[i] + (((m_vd[i] - m_vs[i]) * m_n[i]) >>> SL) : 1000;
  endfunction

  function automatic logic [NS-1:0] exp_active();
    logic [NS-1:0] a;
    for (int i = 0; i < NS; i++) a[i] = m_act[i];
    return a;
  endfunction

  function automatic logic [NS-1:0] exp_done();
    logic [NS-1:0] d;
    for (int i = 0; i < NS; i++) d[i] = m_done[i];
    return d;
  endfunction

  function automatic int exp_free();
    for (int i = 0; i < NS; i++) if (!m_act[i]) return i;
    return -1;
  endfunction

  task automatic cyc(input bit t, input bit r, input logic [NS-1:0] k,
                     input int hs, input int vs, input int hd, input int vd, input bit rs);
    int fr;
    tick = t; req = r; kill = k; rst = rs;
    req_hsrc = hs[HW-1:0]; req_vsrc = vs[VW-1:0];
    req_hdst = hd[HW-1:0]; req_vdst = vd[VW-1:0];
    @(posedge clk);
    fr = exp_free();
    for (int i = 0; i < NS; i++) begin
      m_done[i] = 1'b0;
      if (rs) m_act[i] = 1'b0;
      else if (m_act[i] && k[i]) m_act[i] = 1'b0;
      else if (m_act[i] && t) begin
        if (m_n[i] == NT) begin m_act[i] = 1'b0; m_done[i] = 1'b1; end
        else m_n[i]++;
      end
    end
    if (!rs && r && fr >= 0) begin
      m_act[fr] = 1'b1; m_n[fr] = 0;
      m_hs[fr] = hs; m_vs[fr] = vs; m_hd[fr] = hd; m_vd[fr] = vd;
    end
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, '0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    cyc(0, 0, '0, 0, 0, 0, 0, 1);
    cyc(0, 0, '0, 0, 0, 0, 0, 1);
    total++; if (active !== '0) begin bad++; $display("FAIL reset_active got=%b want=0", active); end
    total++; if (done !== '0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
    total++; if (req_slot !== '0) begin bad++; $display("FAIL reset_slot got=%0d want=0", req_slot); end
    for (int i = 0; i < NS; i++) begin
      total++; if (hoff(i) != 1000 || voff(i) != 1000) begin
        bad++; $display("FAIL reset_offset slot=%0d got=(%0d,%0d) want=(1000,1000)", i, hoff(i), voff(i));
      end
    end
    idle();
  endtask

  task automatic test_single_flight();
    cyc(0, 1, '0, 0, 0, 100, -40, 0);
    total++; if (active[0] !== 1'b1 || hoff(0) != 0 || voff(0) != 0) begin
      bad++; $display("FAIL single_accept active=%b got=(%0d,%0d) want=(0,0)", active, hoff(0), voff(0));
    end
    for (int n = 1; n <= NT; n++) begin
      cyc(1, 0, '0, 0, 0, 0, 0, 0);
      total++; if (hoff(0) != 25*n || voff(0) != -10*n || done !== '0) begin
        bad++; $display("FAIL single_step n=%0d got=(%0d,%0d) done=%b want=(%0d,%0d)", n, hoff(0), voff(0), done, 25*n, -10*n);
      end
    end
    cyc(1, 0, '0, 0, 0, 0, 0, 0);
    total++; if (done !== 4'b0001 || active !== '0 || hoff(0) != 1000 || voff(0) != 1000) begin
      bad++; $display("FAIL single_retire done=%b active=%b got=(%0d,%0d) want done=0001 (1000,1000)", done, active, hoff(0), voff(0));
    end
    idle();
    total++; if (done !== '0) begin bad++; $display("FAIL single_done_pulse got=%b want=0", done); end
  endtask

  task automatic test_nondivisible();
    int eh[4], ev[4];
    eh = '{1, 3, 5, 7};
    ev = '{-2, -4, -6, -7};
    cyc(0, 1, '0, 0, 0, 7, -7, 0);
    for (int n = 0; n < NT; n++) begin
      cyc(1, 0, '0, 0, 0, 0, 0, 0);
      total++; if (hoff(0) != eh[n] || voff(0) != ev[n]) begin
        bad++; $display("FAIL nondiv_step n=%0d got=(%0d,%0d) want=(%0d,%0d)", n+1, hoff(0), voff(0), eh[n], ev[n]);
      end
    end
    cyc(1, 0, '0, 0, 0, 0, 0, 0);
    total++; if (done !== 4'b0001) begin bad++; $display("FAIL nondiv_done got=%b want=0001", done); end
    cyc(0, 1, '0, 33, -5, 33, -5, 0);
    for (int n = 0; n <= NT; n++) begin
      cyc(1, 0, '0, 0, 0, 0, 0, 0);
      if (n < NT) begin
        total++; if (hoff(0) != 33 || voff(0) != -5) begin
          bad++; $display("FAIL zero_len n=%0d got=(%0d,%0d) want=(33,-5)", n+1, hoff(0), voff(0));
        end
      end
    end
    total++; if (done !== 4'b0001) begin bad++; $display("FAIL zero_len_done got=%b want=0001", done); end
    idle();
  endtask

  task automatic test_fill_pool();
    for (int i = 0; i < 5; i++) begin
      if (i < NS) begin
        total++; if (req_ready !== 1'b1 || req_slot !== SW'(i)) begin
          bad++; $display("FAIL fill_slot i=%0d ready=%b slot=%0d want ready=1 slot=%0d", i, req_ready, req_slot, i);
        end
      end else begin
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL fill_full ready=%b want=0", req_ready); end
      end
      cyc(0, 1, '0, 10*i+1, -(10*i+1), 200+8*i, 300, 0);
    end
    total++; if (active !== 4'b1111) begin bad++; $display("FAIL fill_active got=%b want=1111", active); end
    for (int i = 0; i < NS; i++) begin
      total++; if (hoff(i) != 10*i+1 || voff(i) != -(10*i+1)) begin
        bad++; $display("FAIL fill_offset slot=%0d got=(%0d,%0d) want=(%0d,%0d)", i, hoff(i), voff(i), 10*i+1, -(10*i+1));
      end
    end
  endtask

  task automatic test_kill();
    cyc(1, 0, '0, 0, 0, 0, 0, 0);
    cyc(1, 1, 4'b0010, 500, 500, 0, 0, 0);
    total++; if (active !== 4'b1101 || done !== '0) begin
      bad++; $display("FAIL kill_state active=%b done=%b want active=1101 done=0000", active, done);
    end
    total++; if (req_ready !== 1'b1 || req_slot !== 2'd1) begin
      bad++; $display("FAIL kill_free ready=%b slot=%0d want ready=1 slot=1", req_ready, req_slot);
    end
    for (int i = 0; i < NS; i++) begin
      total++; if (hoff(i) != exp_h(i) || voff(i) != exp_v(i)) begin
        bad++; $display("FAIL kill_offset slot=%0d got=(%0d,%0d) want=(%0d,%0d)", i, hoff(i), voff(i), exp_h(i), exp_v(i));
      end
    end
    cyc(1, 1, '0, -77, 88, 0, 0, 0);
    total++; if (active !== 4'b1111 || hoff(1) != -77 || voff(1) != 88) begin
      bad++; $display("FAIL kill_reuse active=%b got=(%0d,%0d) want active=1111 (-77,88)", active, hoff(1), voff(1));
    end
    cyc(0, 0, 4'b1111, 0, 0, 0, 0, 0);
    total++; if (active !== '0 || done !== '0) begin
      bad++; $display("FAIL kill_all active=%b done=%b want 0000/0000", active, done);
    end
  endtask

  task automatic test_rst_midflight();
    cyc(0, 1, '0, -300, 40, 300, -40, 0);
    cyc(1, 1, '0, 10, 10, -10, 20, 0);
    cyc(1, 0, '0, 0, 0, 0, 0, 0);
    total++; if (active !== 4'b0011) begin bad++; $display("FAIL rstmid_pre active=%b want=0011", active); end
    cyc(1, 0, '0, 0, 0, 0, 0, 1);
    total++; if (active !== '0 || done !== '0 || hoff(0) != 1000 || voff(1) != 1000) begin
      bad++; $display("FAIL rstmid_post active=%b done=%b h0=%0d v1=%0d want 0000/0000/1000/1000", active, done, hoff(0), voff(1));
    end
    idle();
    total++; if (done !== '0) begin bad++; $display("FAIL rstmid_done got=%b want=0", done); end
  endtask

  task automatic test_random();
    int ef;
    for (int c = 0; c < 1500; c++) begin
      logic [NS-1:0] k;
      for (int i = 0; i < NS; i++) k[i] = ($urandom_range(0, 19) == 0);
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, k,
          int'($urandom_range(0, 2046)) - 1023, int'($urandom_range(0, 2046)) - 1023,
          int'($urandom_range(0, 2046)) - 1023, int'($urandom_range(0, 2046)) - 1023,
          $urandom_range(0, 299) == 0);
      ef = exp_free();
      total++; if (active !== exp_active() || done !== exp_done()) begin
        bad++; $display("FAIL rand_flags c=%0d active=%b done=%b want active=%b done=%b", c, active, done, exp_active(), exp_done());
      end
      total++; if (req_ready !== (ef >= 0) || (ef >= 0 && req_slot !== SW'(ef))) begin
        bad++; $display("FAIL rand_alloc c=%0d ready=%b slot=%0d want free=%0d", c, req_ready, req_slot, ef);
      end
      for (int i = 0; i < NS; i++) begin
        total++; if (hoff(i) != exp_h(i) || voff(i) != exp_v(i)) begin
          bad++; $display("FAIL rand_offset c=%0d slot=%0d got=(%0d,%0d) want=(%0d,%0d)", c, i, hoff(i), voff(i), exp_h(i), exp_v(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_flight();
    test_nondivisible();
    test_fill_pool();
    test_kill();
    test_rst_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
